// File: rtl/fsm_seq_tx.sv
// Serial pattern transmitter: accepts a WIDTH-bit word over valid/ready and
// shifts it out MSB-first on `a`, then holds `a` low for GAP cycles.
module fsm_seq_tx #(
  parameter int WIDTH = 8,
  parameter int GAP   = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             a,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_GAP   = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_cnt_nxt;
  logic [GW-1:0]    r_gap_cnt;
  logic [GW-1:0]    w_gap_cnt_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_accept;

  assign in_ready = reset & (r_state == ST_IDLE);
  assign w_accept = in_valid & in_ready;

  // State, datapath and done-pulse registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= {WIDTH{1'b0}};
      r_bit_cnt <= {BW{1'b0}};
      r_gap_cnt <= {GW{1'b0}};
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_cnt_nxt;
      r_gap_cnt <= w_gap_cnt_nxt;
      r_done    <= w_done_nxt;
    end
  end

  // Next-state and datapath update; counters are reloaded on every state entry
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_bit_cnt_nxt = r_bit_cnt;
    w_gap_cnt_nxt = r_gap_cnt;
    w_done_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt   = ST_SHIFT;
          w_shift_nxt   = in_data;
          w_bit_cnt_nxt = BW'(WIDTH - 1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (r_bit_cnt == {BW{1'b0}}) begin
          w_state_nxt   = ST_GAP;
          w_gap_cnt_nxt = GW'(GAP - 1);
          w_done_nxt    = 1'b1;
        end else begin
          w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_nxt = r_bit_cnt - BW'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == {GW{1'b0}}) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_gap_cnt_nxt = r_gap_cnt - GW'(1);
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Outputs depend on registered state only, so `a` is low outside SHIFT
  assign a    = (r_state == ST_SHIFT) & r_shift[WIDTH-1];
  assign busy = (r_state != ST_IDLE);
  assign done = r_done;

endmodule

// File: doc/fsm_seq_tx.md
Name: fsm_seq_tx

Overview:
- Serial pattern transmitter FSM. Generates the single-bit serial stream `a` consumed by the team's sequence-detector FSMs.
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out MSB-first, one bit per clock.
- Forces `a` low for GAP idle cycles after each frame, then returns to idle.
- Used as a stimulus source and as the transmit end of the serial link.

Parameters:
- WIDTH, 8, bits per frame (>= 2).
- GAP, 2, number of forced-low cycles after each frame (>= 1).

Ports:
- clk  input  1  clock; all flops update on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = in reset).
- in_valid  input  1  in_data is offered for transmission.
- in_ready  output  1  transmitter can accept a word this cycle.
- in_data  input  WIDTH  word to transmit, MSB sent first.
- a  output  1  serial data out.
- busy  output  1  a frame or its gap is in progress.
- done  output  1  one-cycle pulse: the last bit of the frame has been sent.

Behaviour:
- Reset (reset=0):
  - Asynchronously clears state to IDLE, shift register to 0, counters to 0.
  - While reset is low: a=0, busy=0, done=0, in_ready=0.
  - No handshake can complete while reset is low.
- States (2-bit register): IDLE, SHIFT, GAP.
- Handshake: a word is accepted on a rising edge where in_valid=1 and in_ready=1.
  - in_ready = reset & (state==IDLE).
  - in_data is sampled only at the accepting edge; later changes have no effect on the frame.
  - in_valid may be held high; words are never accepted outside IDLE.
- IDLE -> SHIFT on accept: shift register loaded with in_data, bit counter set to WIDTH-1.
- SHIFT:
  - a = shift register MSB.
  - Shift left by one and decrement the counter each cycle.
  - When counter==0: go to GAP, load gap counter with GAP-1.
- GAP:
  - a=0.
  - Decrement the gap counter; when it reaches 0, go to IDLE.
- Timing, with the accept at edge k:
  - Bit in_data[WIDTH-1-i] drives a during cycle k+1+i, for i = 0..WIDTH-1.
  - done=1 only in cycle k+WIDTH+1 (first GAP cycle).
  - GAP cycles are k+WIDTH+1 .. k+WIDTH+GAP.
  - IDLE (in_ready=1) from cycle k+WIDTH+GAP+1.
  - Minimum frame period is WIDTH+GAP+1 cycles.
- Output decoding:
  - busy = (state != IDLE).
  - a is 0 in every state other than SHIFT.
  - a, busy and done are decoded only from registered state (no path from inputs).
- Counters:
  - Bit counter width is clog2(WIDTH).
  - Gap counter width is clog2(GAP), minimum 1.
  - Neither counter wraps: each is reloaded on state entry.
- Reset mid-frame:
  - Immediate abort: a=0, busy=0, done=0.
  - The partial frame is discarded and never resumed.
  - After release, the next accepted word is sent in full.
- Unreachable state encoding: next state is IDLE, with a=0.

Test Plan:
- Reset release with in_valid=0 -> a=0, busy=0, done=0, in_ready=1 on the first cycle after release, and these hold for 20 cycles.
- Single frame, WIDTH=8, GAP=2, in_data=8'hA5 accepted at edge k ->
  - a = 1,0,1,0,0,1,0,1 over cycles k+1..k+8;
  - done=1 only in k+9;
  - a=0 in k+9..k+10;
  - in_ready=1 again in k+11.
- Back-to-back, in_valid held high with 8'hFF then 8'h00 -> second accept at the edge ending cycle k+11:
  - a high for 8 cycles, low for 2 gap cycles, low for 1 idle cycle, then 8 low data bits;
  - two done pulses, 11 cycles apart.
- in_data changed from 8'hF0 to 8'h0F on the cycle after acceptance -> serial output is still 1,1,1,1,0,0,0,0.
- reset driven low during the 4th bit of 8'hC3 -> a, busy and in_ready drop to 0 immediately with no done pulse; after release, 8'h81 is sent as 1,0,0,0,0,0,0,1.
- Parameter variant WIDTH=4, GAP=1, in_data=4'b1001 -> a = 1,0,0,1, done in the cycle after the last bit, in_ready=1 two cycles after the last bit.
